truth_table_scanner: RTL and testbench
======================================

Name: truth_table_scanner

Overview:
- Sequencer for the 6-input combinational `example` block (inputs A..F, output Y).
- Drives A..F through either a full 64-vector sweep or one chosen vector.
- Waits a programmable settle time before sampling Y into a 64-bit truth-table register and counting ones.
- Sits beside `example` in lab and self-check builds; a simple start/busy/done handshake lets a host or bench capture the function in hardware.

Parameters:
- N_IN, 6, number of driven inputs; vector space is 2^N_IN; only 6 supported in this revision.
- HOLD_CYCLES, 2, settle cycles per vector before sampling; legal range 1..15.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin operation; sampled only in IDLE.
- mode  in  1  0 = full sweep 0..63; 1 = single vector vec_in; captured on start.
- vec_in  in  6  vector for single mode; captured on start.
- abort  in  1  cancel the current operation.
- y_in  in  1  Y from `example`.
- drive  out  6  to `example` inputs: bit5=A, bit4=B, bit3=C, bit2=D, bit1=E, bit0=F.
- busy  out  1  high in DRIVE/SAMPLE.
- done  out  1  one-cycle pulse on normal completion.
- aborted  out  1  sticky; set by abort, cleared by the next accepted start.
- table_out  out  64  bit k = sampled Y for drive==k.
- ones_count  out  7  number of samples with Y=1 in the current or last run (0..64).

Behaviour:
- Reset values: state IDLE; drive=0, busy=0, done=0, aborted=0, table_out=0, ones_count=0, hold counter=0. Reset mid-operation aborts silently: no done, aborted=0.
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE:
  - start=1 accepts the request.
  - On acceptance, clear table_out and ones_count, clear aborted, latch mode, then go to DRIVE.
  - drive loads 0 (sweep) or vec_in (single).
- DRIVE:
  - drive is held stable for exactly HOLD_CYCLES cycles; the counter counts 0..HOLD_CYCLES-1.
  - When the count reaches HOLD_CYCLES-1, go to SAMPLE.
- SAMPLE (one cycle):
  - Register table_out[drive] <= y_in; ones_count <= ones_count + y_in.
  - Next state is DONE if single mode or drive==63.
  - Otherwise drive <= drive+1 and return to DRIVE with the counter reset to 0.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE. drive holds its last value.
- Latency: with the start edge as cycle 0, done is high in cycle V*(HOLD_CYCLES+1)+1, where V=64 (sweep) or 1 (single).
  - Example: HOLD_CYCLES=2 gives 193 for a sweep and 4 for single.
- Per-vector timing: each vector occupies exactly HOLD_CYCLES+1 cycles; drive changes only on the DRIVE-entry edge.
- start while busy or in DONE: ignored; no queuing.
- abort:
  - In DRIVE or SAMPLE: next state is IDLE, aborted=1, no done pulse, and the SAMPLE write in that cycle is suppressed.
  - Partial table_out and ones_count are retained.
  - In IDLE or DONE, abort has no effect.
- Simultaneous start+abort in IDLE: start wins; abort is ignored that cycle.
- Wrap-around: drive never wraps; a sweep ends at 63.
- ones_count is 7 bits and saturates naturally at 64 (it cannot exceed 64).
- Outputs table_out, ones_count and aborted hold stable in IDLE until the next accepted start.

Decomposition:
- Shared package `tts_pkg` holds:
  - the state encoding constants (IDLE=2'd0, DRIVE=2'd1, SAMPLE=2'd2, DONE=2'd3);
  - the N_IN default;
  - the HOLD_CYCLES legal-range limits.
- One natural sub-module, `settle_counter`:
  - 4-bit counter with clear and enable;
  - asserts `expired` when count == HOLD_CYCLES-1.
- FSM, vector register and capture logic stay in the top.

Test Plan:
- Full sweep, y_in tied to drive[5] (Y=A), HOLD_CYCLES=2 -> done at cycle 193, table_out=64'hFFFF_FFFF_0000_0000, ones_count=32, aborted=0.
- Single mode, vec_in=6'b100100, y_in=1 -> drive=36 within cycles 1..3, done at cycle 4, table_out=64'h0000_0010_0000_0000, ones_count=1.
- Sweep with y_in=drive[0]&drive[1] (Y=E&F), abort asserted in cycle 50 -> IDLE next cycle, no done pulse, aborted=1, ones_count=4, table_out=64'h0000_0000_0000_8888.
- start pulsed at cycle 10 of a busy sweep -> ignored; done still at 193; a later start clears aborted, table_out and ones_count.
- rst asserted at cycle 100 of a sweep -> next cycle all outputs at reset values, no done; a subsequent sweep with y_in=1 -> table_out=all ones, ones_count=64.
- Per-vector hold check: monitor drive during a sweep -> each value is stable for exactly 3 cycles at HOLD_CYCLES=2; rerun with HOLD_CYCLES=1 -> done at cycle 129.

Source files
------------

// File: rtl/truth_table_scanner_pkg.sv
// Shared definitions for the truth-table scanner: FSM encoding, input-count
// default and the legal settle-time range.
package tts_pkg;

    localparam int N_IN_DEFAULT = 6;
    localparam int HOLD_DEFAULT = 2;
    localparam int HOLD_MIN     = 1;
    localparam int HOLD_MAX     = 15;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // Terminal count for the settle counter; out-of-range settings are pulled
    // back into the legal window so the 4-bit counter can always reach it.
    function automatic logic [3:0] hold_last(input int hold_cycles);
        int h;
        h = hold_cycles;
        if (h < HOLD_MIN) h = HOLD_MIN;
        if (h > HOLD_MAX) h = HOLD_MAX;
        return 4'(h - 1);
    endfunction

endpackage

// File: rtl/truth_table_scanner_if.sv
// Host-side bundle of the scanner: start/mode/vector request, abort, the Y
// feedback from the block under test, and the status/result outputs.
interface truth_table_scanner_if #(
    parameter int N_IN = tts_pkg::N_IN_DEFAULT
);
    // start is a level-sampled request: it is taken only while the scanner is
    // idle (busy=0, done=0); done pulses for one cycle after a full run.
    logic                 start;
    logic                 mode;
    logic [N_IN-1:0]      vec_in;
    logic                 abort;
    logic                 y_in;
    logic [N_IN-1:0]      drive;
    logic                 busy;
    logic                 done;
    logic                 aborted;
    logic [2**N_IN-1:0]   table_out;
    logic [N_IN:0]        ones_count;
    tts_pkg::state_e      dbg_state;

    modport master (
        output start, mode, vec_in, abort, y_in,
        input  drive, busy, done, aborted, table_out, ones_count, dbg_state
    );

    modport slave (
        input  start, mode, vec_in, abort, y_in,
        output drive, busy, done, aborted, table_out, ones_count, dbg_state
    );

endinterface

// File: rtl/truth_table_scanner_settle_counter.sv
// Settle-time counter: counts up while enabled, flags the terminal count so
// the scanner knows the driven vector has been stable long enough.
module settle_counter #(
    parameter logic [3:0] LAST = 4'd1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic expired
);

    logic [3:0] count_q;
    logic [3:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = 4'd0;
        end else if (en) begin
            count_d = count_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 4'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == LAST);

endmodule

// File: rtl/truth_table_scanner.sv
// Sequencer that walks the inputs of a combinational block (one vector or the
// whole space), waits a settle time per vector and records Y into a table.
module truth_table_scanner
    import tts_pkg::*;
#(
    parameter int N_IN        = N_IN_DEFAULT,
    parameter int HOLD_CYCLES = HOLD_DEFAULT
) (
    input logic                  clk,
    input logic                  rst,
    truth_table_scanner_if.slave bus
);

    localparam int              VECS      = 2**N_IN;
    localparam logic [N_IN-1:0] VEC_LAST  = '1;
    localparam logic [N_IN-1:0] VEC_ONE   = 1;
    localparam logic [N_IN:0]   ONES_ZERO = '0;

    state_e             state_q, state_d;
    logic [N_IN-1:0]    drive_q, drive_d;
    logic               mode_q, mode_d;
    logic [VECS-1:0]    table_q, table_d;
    logic [N_IN:0]      ones_q, ones_d;
    logic               aborted_q, aborted_d;
    logic               cnt_clear;
    logic               cnt_en;
    logic               hold_expired;

    settle_counter #(
        .LAST (hold_last(HOLD_CYCLES))
    ) u_settle (
        .clk     (clk),
        .rst     (rst),
        .clear   (cnt_clear),
        .en      (cnt_en),
        .expired (hold_expired)
    );

    always_comb begin
        state_d   = state_q;
        drive_d   = drive_q;
        mode_d    = mode_q;
        table_d   = table_q;
        ones_d    = ones_q;
        aborted_d = aborted_q;
        cnt_clear = 1'b1;
        cnt_en    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // start outranks abort here: abort only acts on a running scan
                if (bus.start) begin
                    state_d   = ST_DRIVE;
                    mode_d    = bus.mode;
                    drive_d   = bus.mode ? bus.vec_in : '0;
                    table_d   = '0;
                    ones_d    = ONES_ZERO;
                    aborted_d = 1'b0;
                end
            end

            ST_DRIVE: begin
                cnt_clear = 1'b0;
                cnt_en    = 1'b1;
                if (bus.abort) begin
                    state_d   = ST_IDLE;
                    aborted_d = 1'b1;
                end else if (hold_expired) begin
                    state_d = ST_SAMPLE;
                end
            end

            ST_SAMPLE: begin
                if (bus.abort) begin
                    state_d   = ST_IDLE;
                    aborted_d = 1'b1;
                end else begin
                    table_d[drive_q] = bus.y_in;
                    ones_d           = ones_q + {{N_IN{1'b0}}, bus.y_in};
                    if (mode_q || (drive_q == VEC_LAST)) begin
                        state_d = ST_DONE;
                    end else begin
                        drive_d = drive_q + VEC_ONE;
                        state_d = ST_DRIVE;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            drive_q   <= '0;
            mode_q    <= 1'b0;
            table_q   <= '0;
            ones_q    <= ONES_ZERO;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            drive_q   <= drive_d;
            mode_q    <= mode_d;
            table_q   <= table_d;
            ones_q    <= ones_d;
            aborted_q <= aborted_d;
        end
    end

    assign bus.drive      = drive_q;
    assign bus.busy       = (state_q == ST_DRIVE) || (state_q == ST_SAMPLE);
    assign bus.done       = (state_q == ST_DONE);
    assign bus.aborted    = aborted_q;
    assign bus.table_out  = table_q;
    assign bus.ones_count = ones_q;
    assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Directed bench for truth_table_scanner: one instance at HOLD_CYCLES=2 and
// one at HOLD_CYCLES=1, driven through sweeps, single vectors, abort and reset.
module tb_truth_table_scanner;
    import tts_pkg::*;

    logic       clk;
    logic       rst;
    logic       start;
    logic       mode;
    logic [5:0] vec;
    logic       abort;
    logic       use_b;
    logic [1:0] y_sel;
    logic       ya, yb;

    int n_total;
    int n_pass;
    int n_fail;
    int dc;
    int bs;

    truth_table_scanner_if #(.N_IN(6)) bus_a ();
    truth_table_scanner_if #(.N_IN(6)) bus_b ();

    truth_table_scanner #(.N_IN(6), .HOLD_CYCLES(2)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    truth_table_scanner #(.N_IN(6), .HOLD_CYCLES(1)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    // Y models: 0 -> A, 1 -> E&F, 2 -> constant 1, 3 -> constant 0
    always_comb begin
        case (y_sel)
            2'd0:    ya = bus_a.drive[5];
            2'd1:    ya = bus_a.drive[1] & bus_a.drive[0];
            2'd2:    ya = 1'b1;
            default: ya = 1'b0;
        endcase
        case (y_sel)
            2'd0:    yb = bus_b.drive[5];
            2'd1:    yb = bus_b.drive[1] & bus_b.drive[0];
            2'd2:    yb = 1'b1;
            default: yb = 1'b0;
        endcase
    end

    assign bus_a.start  = start & ~use_b;
    assign bus_a.mode   = mode;
    assign bus_a.vec_in = vec;
    assign bus_a.abort  = abort;
    assign bus_a.y_in   = ya;
    assign bus_b.start  = start & use_b;
    assign bus_b.mode   = mode;
    assign bus_b.vec_in = vec;
    assign bus_b.abort  = abort;
    assign bus_b.y_in   = yb;

    logic [5:0]  obs_drive;
    logic        obs_busy, obs_done, obs_aborted;
    logic [63:0] obs_table;
    logic [6:0]  obs_ones;
    state_e      obs_state;

    assign obs_drive   = use_b ? bus_b.drive      : bus_a.drive;
    assign obs_busy    = use_b ? bus_b.busy       : bus_a.busy;
    assign obs_done    = use_b ? bus_b.done       : bus_a.done;
    assign obs_aborted = use_b ? bus_b.aborted    : bus_a.aborted;
    assign obs_table   = use_b ? bus_b.table_out  : bus_a.table_out;
    assign obs_ones    = use_b ? bus_b.ones_count : bus_a.ones_count;
    assign obs_state   = use_b ? bus_b.dbg_state  : bus_a.dbg_state;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Request an operation; the start edge ends the cycle begun here (cycle 0).
    task automatic start_op(input logic m, input logic [5:0] v);
        @(negedge clk);
        mode  = m;
        vec   = v;
        start = 1'b1;
    endtask

    // Walk cycles c0..max_c after the start edge until done is seen. While the
    // scan is in progress drive must match the vector schedule and busy must
    // be high. start/abort/rst pulses are placed at the requested cycles.
    task automatic run_op(input int c0, input int max_c, input int period,
                          input bit single, input logic [5:0] v,
                          input int start_at, input int abort_at, input int rst_at,
                          output int done_c, output int bad_seq);
        int last_chk;
        logic [5:0] exp_drive;
        done_c   = -1;
        bad_seq  = 0;
        last_chk = single ? period : 64 * period;
        for (int c = c0; c <= max_c; c++) begin
            @(negedge clk);
            if (obs_done) begin
                done_c = c;
                start  = 1'b0;
                abort  = 1'b0;
                break;
            end
            if (period > 0 && c <= last_chk) begin
                exp_drive = single ? v : 6'((c - 1) / period);
                if (obs_drive !== exp_drive || obs_busy !== 1'b1) bad_seq++;
            end
            start = (c == start_at);
            abort = (c == abort_at);
            rst   = (c == rst_at);
        end
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        n_fail  = 0;
        rst     = 1'b1;
        start   = 1'b0;
        mode    = 1'b0;
        vec     = 6'd0;
        abort   = 1'b0;
        use_b   = 1'b0;
        y_sel   = 2'd0;

        repeat (3) @(negedge clk);
        check("rst_drive",   64'(obs_drive),   64'd0);
        check("rst_busy",    64'(obs_busy),    64'd0);
        check("rst_done",    64'(obs_done),    64'd0);
        check("rst_aborted", 64'(obs_aborted), 64'd0);
        check("rst_table",   obs_table,        64'd0);
        check("rst_ones",    64'(obs_ones),    64'd0);
        check("rst_state",   64'(obs_state),   64'(ST_IDLE));
        rst = 1'b0;

        // Full sweep, Y=A, with a stray start at cycle 10
        y_sel = 2'd0;
        start_op(1'b0, 6'd0);
        run_op(1, 250, 3, 1'b0, 6'd0, 10, 0, 0, dc, bs);
        check("sweepA_done_cycle", 64'(dc), 64'd193);
        check("sweepA_sequence",   64'(bs), 64'd0);
        check("sweepA_table",      obs_table, 64'hFFFF_FFFF_0000_0000);
        check("sweepA_ones",       64'(obs_ones), 64'd32);
        check("sweepA_aborted",    64'(obs_aborted), 64'd0);
        check("sweepA_busy_in_done", 64'(obs_busy), 64'd0);
        check("sweepA_drive_last", 64'(obs_drive), 64'd63);
        @(negedge clk);
        check("sweepA_idle_after", 64'(obs_state), 64'(ST_IDLE));
        check("sweepA_done_pulse", 64'(obs_done), 64'd0);
        check("sweepA_table_hold", obs_table, 64'hFFFF_FFFF_0000_0000);

        // Single vector 36, Y=1
        y_sel = 2'd2;
        start_op(1'b1, 6'b100100);
        run_op(1, 20, 3, 1'b1, 6'd36, 0, 0, 0, dc, bs);
        check("single36_done_cycle", 64'(dc), 64'd4);
        check("single36_drive",      64'(bs), 64'd0);
        check("single36_table",      obs_table, 64'h0000_0010_0000_0000);
        check("single36_ones",       64'(obs_ones), 64'd1);

        // Sweep with Y=E&F, aborted in cycle 50
        y_sel = 2'd1;
        start_op(1'b0, 6'd0);
        run_op(1, 50, 3, 1'b0, 6'd0, 0, 50, 0, dc, bs);
        check("abort_no_done_early", 64'(dc), 64'(-1));
        check("abort_sequence",      64'(bs), 64'd0);
        @(negedge clk);
        abort = 1'b0;
        check("abort_state",   64'(obs_state),   64'(ST_IDLE));
        check("abort_busy",    64'(obs_busy),    64'd0);
        check("abort_done",    64'(obs_done),    64'd0);
        check("abort_flag",    64'(obs_aborted), 64'd1);
        check("abort_ones",    64'(obs_ones),    64'd4);
        check("abort_table",   obs_table,        64'h0000_0000_0000_8888);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        @(negedge clk);
        check("idle_abort_state", 64'(obs_state), 64'(ST_IDLE));
        check("idle_abort_flag",  64'(obs_aborted), 64'd1);
        check("idle_abort_table", obs_table, 64'h0000_0000_0000_8888);

        // Start together with abort: start wins and clears the previous result
        start_op(1'b1, 6'd3);
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("restart_busy",    64'(obs_busy),    64'd1);
        check("restart_aborted", 64'(obs_aborted), 64'd0);
        check("restart_table",   obs_table,        64'd0);
        check("restart_ones",    64'(obs_ones),    64'd0);
        run_op(2, 20, 3, 1'b1, 6'd3, 0, 0, 0, dc, bs);
        check("single3_done_cycle", 64'(dc), 64'd4);
        check("single3_drive",      64'(bs), 64'd0);
        check("single3_table",      obs_table, 64'h0000_0000_0000_0008);
        check("single3_ones",       64'(obs_ones), 64'd1);

        // Reset in cycle 100 of a Y=1 sweep
        y_sel = 2'd2;
        start_op(1'b0, 6'd0);
        run_op(1, 100, 3, 1'b0, 6'd0, 0, 0, 100, dc, bs);
        check("rst_mid_no_done", 64'(dc), 64'(-1));
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_drive",   64'(obs_drive),   64'd0);
        check("rst_mid_busy",    64'(obs_busy),    64'd0);
        check("rst_mid_done",    64'(obs_done),    64'd0);
        check("rst_mid_aborted", 64'(obs_aborted), 64'd0);
        check("rst_mid_table",   obs_table,        64'd0);
        check("rst_mid_ones",    64'(obs_ones),    64'd0);
        check("rst_mid_state",   64'(obs_state),   64'(ST_IDLE));
        run_op(1, 20, 0, 1'b0, 6'd0, 0, 0, 0, dc, bs);
        check("rst_mid_quiet", 64'(dc), 64'(-1));

        // Full Y=1 sweep after reset
        start_op(1'b0, 6'd0);
        run_op(1, 250, 3, 1'b0, 6'd0, 0, 0, 0, dc, bs);
        check("sweep1_done_cycle", 64'(dc), 64'd193);
        check("sweep1_sequence",   64'(bs), 64'd0);
        check("sweep1_table",      obs_table, 64'hFFFF_FFFF_FFFF_FFFF);
        check("sweep1_ones",       64'(obs_ones), 64'd64);

        // HOLD_CYCLES=1 instance, Y=A sweep
        @(negedge clk);
        use_b = 1'b1;
        y_sel = 2'd0;
        start_op(1'b0, 6'd0);
        run_op(1, 200, 2, 1'b0, 6'd0, 0, 0, 0, dc, bs);
        check("h1_done_cycle", 64'(dc), 64'd129);
        check("h1_sequence",   64'(bs), 64'd0);
        check("h1_table",      obs_table, 64'hFFFF_FFFF_0000_0000);
        check("h1_ones",       64'(obs_ones), 64'd32);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
